mac_unit_pipelined: RTL and testbench

Signed multiply-accumulate unit with a two-stage registered pipeline: computes `c_out = a*b + c_in`. It is the arithmetic datapath instantiated by the sequential 1-D convolution controller. The controller drives operands and the running partial sum, holds them for three cycles, and samples `c_out` on the third clock edge. The unit is fully pipelined, so new operands may be accepted every enabled cycle.

---
 rtl/mac_unit_pipelined.sv | 65 ++++++
 tb/tb_mac_unit_pipelined.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mac_unit_pipelined.sv
// Two-stage signed multiply-accumulate: c_out = a*b + c_in, wrapping modulo 2^ACCUM_WIDTH.
// Stage _p1 holds the exact product and the addend; stage _p2 holds the accumulated result.
module mac_unit_pipelined #(
   parameter int DATA_WIDTH  = 8,
   parameter int ACCUM_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [DATA_WIDTH-1:0]  a,
   input  logic [DATA_WIDTH-1:0]  b,
   input  logic [ACCUM_WIDTH-1:0] c_in,
   output logic [ACCUM_WIDTH-1:0] c_out
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   // Sign-extend the exact product into the accumulator width.
   function automatic logic signed [ACCUM_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return ACCUM_WIDTH'(p);
   endfunction

   // Two's complement add that wraps silently; no saturation by design.
   function automatic logic signed [ACCUM_WIDTH-1:0] wrap_add(input logic signed [ACCUM_WIDTH-1:0] x,
                                                               input logic signed [ACCUM_WIDTH-1:0] y);
      return x + y;
   endfunction

   logic signed [DATA_WIDTH-1:0]  a_p0;
   logic signed [DATA_WIDTH-1:0]  b_p0;
   logic signed [ACCUM_WIDTH-1:0] c_p0;
   logic signed [PROD_W-1:0]      prod_p0;

   logic signed [PROD_W-1:0]      prod_p1;
   logic signed [ACCUM_WIDTH-1:0] c_p1;
   logic signed [ACCUM_WIDTH-1:0] sum_p2;

   assign a_p0    = a;
   assign b_p0    = b;
   assign c_p0    = c_in;
   assign prod_p0 = a_p0 * b_p0;

   // ---- stage 1: exact product and addend capture ----
   always_ff @(posedge clk) begin
      if (rst_n) begin
         prod_p1 <= '0;
         c_p1    <= '0;
      end else if (en) begin
         prod_p1 <= prod_p0;
         c_p1    <= c_p0;
      end
   end

   // ---- stage 2: accumulate ----
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sum_p2 <= '0;
      end else if (en) begin
         sum_p2 <= wrap_add(sext_prod(prod_p1), c_p1);
      end
   end

   assign c_out = sum_p2;

endmodule

// File: tb/tb_mac_unit_pipelined.sv
// Scoreboard bench for mac_unit_pipelined: directed plan items plus randomized traffic,
// with an every-cycle monitor comparing c_out to a result-history reference model.
module tb_mac_unit_pipelined;

   localparam int DW = 8;
   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [DW-1:0] a = '0;
   logic [DW-1:0] b = '0;
   logic [AW-1:0] c_in = '0;
   logic [AW-1:0] c_out;

   int vectors = 0;
   int miscompares = 0;
   bit armed = 1'b0;

   // Results issued on enabled edges since the last reset; the output lags two enabled edges.
   logic [AW-1:0] exp_q[$];

   mac_unit_pipelined #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] mac_ref(input int av, input int bv, input int cv);
      longint s;
      s = longint'(av) * longint'(bv) + longint'(cv);
      return s[AW-1:0];
   endfunction

   task automatic step(input logic r, input logic e, input int av, input int bv, input int cv);
      rst_n = r;
      en    = e;
      a     = av[DW-1:0];
      b     = bv[DW-1:0];
      c_in  = cv[AW-1:0];
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         armed = 1'b1;
      end else if (e) begin
         exp_q.push_back(mac_ref(av, bv, cv));
         if (exp_q.size() > 2) void'(exp_q.pop_front());
      end
   endtask

   task automatic check(input string name, input logic [AW-1:0] want);
      vectors++;
      if (c_out !== want) begin
         miscompares++;
         $display("FAIL %s: c_out=%0d (0x%h) expected %0d (0x%h)", name,
                  $signed(c_out), c_out, $signed(want), want);
      end
   endtask

   // Monitor: every cycle after the first reset, c_out must match the model's pending result.
   always @(negedge clk) begin
      logic [AW-1:0] want;
      if (armed) begin
         want = (exp_q.size() == 2) ? exp_q[0] : '0;
         vectors++;
         if (c_out !== want) begin
            miscompares++;
            $display("FAIL pipe @%0t: c_out=0x%h expected 0x%h", $time, c_out, want);
         end
      end
   end

   initial begin
      int x[8] = '{1, 2, 3, 4, 1, 1, 1, 1};
      int k[3] = '{1, 2, 1};
      int win[6] = '{8, 12, 12, 7, 4, 4};
      int acc;

      // Reset with arbitrary inputs and en high
      step(1'b1, 1'b1, 77, -9, 1234);
      step(1'b1, 1'b1, -100, 55, 999);
      check("reset", 24'd0);
      step(1'b0, 1'b1, 3, 4, 5);
      check("after_rst_1", 24'd0);
      step(1'b0, 1'b1, 3, 4, 5);
      check("after_rst_2", 24'd17);

      // Convolution sweep, each MAC held for three cycles
      for (int w = 0; w < 6; w++) begin
         acc = 0;
         for (int t = 0; t < 3; t++) begin
            for (int h = 0; h < 3; h++) step(1'b0, 1'b1, x[w+t], k[t], acc);
            acc = int'(c_out);
         end
         check($sformatf("conv_w%0d", w), win[w][AW-1:0]);
      end

      // Signed corners and wrap
      step(1'b0, 1'b1, -128, -128, 0);
      step(1'b0, 1'b1, -128, -128, 0);
      check("neg_x_neg", 24'd16384);
      step(1'b0, 1'b1, -128, 127, 100);
      step(1'b0, 1'b1, -128, 127, 100);
      check("neg_x_pos", 24'hFFC0E4);
      step(1'b0, 1'b1, -1, 1, 0);
      step(1'b0, 1'b1, -1, 1, 0);
      check("minus_one", 24'hFFFFFF);
      step(1'b0, 1'b1, 1, 1, 24'h7FFFFF);
      step(1'b0, 1'b1, 1, 1, 24'h7FFFFF);
      check("wrap", 24'h800000);

      // Back-to-back operands, then stall
      step(1'b0, 1'b1, 2, 3, 0);
      step(1'b0, 1'b1, 4, 5, 1);
      check("b2b_0", 24'd6);
      step(1'b0, 1'b1, -6, 7, 0);
      check("b2b_1", 24'd21);
      step(1'b0, 1'b1, -6, 7, 0);
      check("b2b_2", 24'hFFFFD6);
      for (int s = 0; s < 3; s++) begin
         step(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1000));
         check("stall", 24'hFFFFD6);
      end

      // Reset between operands of a stream
      step(1'b0, 1'b1, 1, 1, 10);
      step(1'b0, 1'b1, 2, 2, 20);
      step(1'b1, 1'b1, 3, 3, 30);
      check("mid_rst", 24'd0);
      step(1'b0, 1'b1, 4, 4, 40);
      check("mid_rst_flush", 24'd0);
      step(1'b0, 1'b1, 5, 5, 50);
      check("mid_rst_first", 24'd56);

      // Randomized traffic with sporadic stalls and resets
      for (int i = 0; i < 400; i++) begin
         int ra, rb, rc;
         ra = int'($urandom_range(0, 255)) - 128;
         rb = int'($urandom_range(0, 255)) - 128;
         rc = int'($urandom_range(0, 24'hFFFFFF));
         if (($urandom % 10) == 0) ra = (($urandom % 2) == 0) ? -128 : 127;
         step(($urandom % 40) == 0, ($urandom % 4) != 0, ra, rb, rc);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
